// File: rtl/wbdma.sv
// wbdma: single-channel Wishbone DMA engine that copies or fills blocks of 32-bit words.
//
// Ports:
//   wb_clk_i, wb_reset_i        clock; asynchronous active-low reset
//   wb_adr_i .. wb_ack_o        Wishbone slave port: SRC(0), DST(1), LEN(2), CTRL/STAT(3)
//   m_adr_o .. m_ack_i          Wishbone master port towards the memory slaves
// Optional feature: define WBDMA_FILL_EN to honour the FILL bit (pattern fill from SRC).
module wbdma #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LEN_BITS = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    input  logic            wb_we_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    output logic [AW-1:0]   m_adr_o,
    output logic [DW-1:0]   m_dat_o,
    input  logic [DW-1:0]   m_dat_i,
    output logic            m_we_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    input  logic            m_ack_i
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d, wsrc_q, wsrc_d, wdst_q, wdst_d, adr_q, adr_d;
    logic [LEN_BITS-1:0] len_q, len_d, rem_q, rem_d;
    logic [DW-1:0] data_q, data_d, dat_o_q, dat_o_d;
    logic ack_q, ack_d, go_q, go_d, fill_q, fill_d, abort_q, abort_d;
    logic aborted_q, aborted_d, done_q, done_d, cyc_q, cyc_d, we_q, we_d;
    logic acc, wr, busy, ctrl_wr, start, abort;
    logic unused_adr;
    assign unused_adr = ^wb_adr_i[AW-1:2];
    always_comb begin
        acc       = wb_cyc_i & wb_stb_i & ~ack_q;
        wr        = acc & wb_we_i & (wb_sel_i == '1);
        // go_q covers the cycle between the START write and the first master request
        busy      = go_q | (state_q == READ) | (state_q == WRITE);
        ctrl_wr   = wr & (wb_adr_i[1:0] == 2'd3);
        start     = ctrl_wr & wb_dat_i[0] & ~busy;
        // an ABORT arriving in the same cycle as an ack still ends the transfer
        abort     = abort_q | (ctrl_wr & wb_dat_i[2] & busy);
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        wsrc_d    = wsrc_q;
        wdst_d    = wdst_q;
        rem_d     = rem_q;
        data_d    = data_q;
        go_d      = go_q;
        fill_d    = fill_q;
        abort_d   = abort;
        aborted_d = aborted_q;
        done_d    = done_q;
        ack_d     = acc;
        dat_o_d   = '0;
        if (acc)
            dat_o_d = (wb_adr_i[1:0] == 2'd0) ? DW'(src_q) :
                      (wb_adr_i[1:0] == 2'd1) ? DW'(dst_q) :
                      (wb_adr_i[1:0] == 2'd2) ? DW'(len_q) :
                      DW'({done_q, aborted_q, fill_q, busy});
        if (wr & ~busy) begin
            src_d = (wb_adr_i[1:0] == 2'd0) ? AW'(wb_dat_i) : src_q;
            dst_d = (wb_adr_i[1:0] == 2'd1) ? AW'(wb_dat_i) : dst_q;
            len_d = (wb_adr_i[1:0] == 2'd2) ? wb_dat_i[LEN_BITS-1:0] : len_q;
        end
        if (ctrl_wr & wb_dat_i[3]) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end
        if (start) begin
            wsrc_d    = src_q;
            wdst_d    = dst_q;
            rem_d     = len_q;
            go_d      = (len_q != '0);
            done_d    = (len_q == '0);
            aborted_d = 1'b0;
            abort_d   = 1'b0;
`ifdef WBDMA_FILL_EN
            fill_d    = wb_dat_i[1];
`else
            fill_d    = 1'b0;
`endif
        end
        case (state_q)
            IDLE: if (go_q) begin
                go_d    = 1'b0;
                state_d = fill_q ? WRITE : READ;
                data_d  = DW'(wsrc_q);
            end
            READ: if (m_ack_i) begin
                data_d  = m_dat_i;
                state_d = abort ? DONE : WRITE;
            end
            WRITE: if (m_ack_i) begin
                wsrc_d  = wsrc_q + 1'b1;
                wdst_d  = wdst_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (abort || rem_q == LEN_BITS'(1)) ? DONE : fill_q ? WRITE : READ;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != DONE && state_d == DONE) begin
            done_d    = 1'b1;
            aborted_d = abort;
            abort_d   = 1'b0;
        end
        // master outputs are registered from the next state so they hold until ack
        cyc_d = (state_d == READ) | (state_d == WRITE);
        we_d  = (state_d == WRITE);
        adr_d = we_d ? wdst_d : wsrc_d;
    end
    always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
        if (!wb_reset_i) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            wsrc_q    <= '0;
            wdst_q    <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            dat_o_q   <= '0;
            adr_q     <= '0;
            ack_q     <= 1'b0;
            go_q      <= 1'b0;
            fill_q    <= 1'b0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            wsrc_q    <= wsrc_d;
            wdst_q    <= wdst_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            dat_o_q   <= dat_o_d;
            adr_q     <= adr_d;
            ack_q     <= ack_d;
            go_q      <= go_d;
            fill_q    <= fill_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
        end
    end
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_o_q;
    assign m_adr_o  = adr_q;
    assign m_dat_o  = data_q;
    assign m_we_o   = we_q;
    assign m_cyc_o  = cyc_q;
    assign m_stb_o  = cyc_q;
    assign m_sel_o  = {(DW/8){cyc_q}};
endmodule

// File: tb/tb_wbdma.sv
// tb_wbdma: randomized self-checking bench for wbdma against a transaction-level model.
module tb_wbdma;
`ifdef WBDMA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } tr_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r, m_adr, m_dat_o, m_dat_i;
    logic [3:0] wb_sel, m_sel;
    logic wb_we, wb_cyc, wb_stb, wb_ack, m_we, m_cyc, m_stb, mem_ack;
    logic ld_en;
    logic [9:0] ld_adr;
    logic [31:0] ld_dat;
    logic [31:0] mem [1024];
    logic [31:0] sh [1024];
    tr_t exp_q [$];
    int checks = 0, errors = 0;
    int cyc_cnt, nwr, nrd;
    logic [31:0] rd_log [2];
    logic mon_en = 1'b0;

    wbdma dut (
        .wb_clk_i(clk), .wb_reset_i(rst_n),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
        .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_ack_o(wb_ack),
        .m_adr_o(m_adr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we),
        .m_sel_o(m_sel), .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_ack_i(mem_ack)
    );

    // one-cycle-ack memory slave with ~ack gating, 1024 words aliased on adr[9:0]
    always @(posedge clk) begin
        mem_ack <= m_cyc & m_stb & ~mem_ack;
        if (m_cyc & m_stb & ~mem_ack) begin
            if (m_we) mem[m_adr[9:0]] <= m_dat_o;
            m_dat_i <= mem[m_adr[9:0]];
        end
        if (ld_en) mem[ld_adr] <= ld_dat;
    end

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hC3C30000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic monitor();
        tr_t e;
        logic p_pend, p_we;
        logic [31:0] p_adr, p_dat;
        p_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                p_pend = 1'b0;
                continue;
            end
            chk("stb follows cyc", {31'b0, m_stb}, {31'b0, m_cyc});
            chk("sel", {28'b0, m_sel}, m_cyc ? 32'hF : 32'h0);
            if (m_cyc) cyc_cnt++;
            if (m_cyc && p_pend) begin
                chk("held adr", m_adr, p_adr);
                chk("held we", {31'b0, m_we}, {31'b0, p_we});
                if (p_we) chk("held dat", m_dat_o, p_dat);
            end
            if (m_cyc && mem_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected bus cycle: got we=%b adr=%h expected none", m_we, m_adr);
                end else begin
                    e = exp_q.pop_front();
                    chk("bus we", {31'b0, m_we}, {31'b0, e.we});
                    chk("bus adr", m_adr, e.adr);
                    if (e.we) begin
                        chk("bus wdata", m_dat_o, e.dat);
                        sh[e.adr[9:0]] = e.dat;
                    end
                end
                if (m_we) nwr++;
                else begin
                    if (nrd < 2) rd_log[nrd] = m_adr;
                    nrd++;
                end
            end
            p_pend = m_cyc && !mem_ack;
            p_adr  = m_adr;
            p_we   = m_we;
            p_dat  = m_dat_o;
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] sel, output logic [31:0] r);
        int n;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = {30'b0, a}; wb_dat_w = d; wb_sel = sel;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 8);
        r = wb_dat_r;
        if (!wb_ack) begin
            checks++; errors++;
            $display("FAIL slave ack timeout: got no ack expected ack within 8 cycles");
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        xfer(1'b1, a, d, 4'hF, r);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        xfer(1'b0, a, 32'h0, 4'hF, r);
    endtask

    task automatic load(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_adr = 10'(a); ld_dat = d;
        sh[a] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // transaction model: each word is one read then one write, or one write of SRC when filling
    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input logic [3:0] ctrl);
        logic [31:0] w [16];
        logic [31:0] a, b, v;
        tr_t t;
        wr(2'd0, s); wr(2'd1, d); wr(2'd2, 32'(n));
        for (int i = 0; i < n; i++) begin
            if (ctrl[1] & FILL_EN) begin
                t.we = 1'b1; t.adr = d + 32'(i); t.dat = s;
                exp_q.push_back(t);
            end else begin
                a = s + 32'(i);
                v = sh[a[9:0]];
                for (int j = 0; j < i; j++) begin
                    b = d + 32'(j);
                    if (b[9:0] == a[9:0]) v = w[j];
                end
                w[i] = v;
                t.we = 1'b0; t.adr = a; t.dat = 32'h0;
                exp_q.push_back(t);
                t.we = 1'b1; t.adr = d + 32'(i); t.dat = v;
                exp_q.push_back(t);
            end
        end
        cyc_cnt = 0; nwr = 0; nrd = 0;
        wr(2'd3, {28'b0, ctrl});
    endtask

    task automatic wait_done(output logic [31:0] st);
        int n;
        n = 0;
        do begin
            rd(2'd3, st);
            n++;
        end while (st[0] && n < 200);
        if (st[0]) begin
            checks++; errors++;
            $display("FAIL done timeout: got BUSY=1 expected BUSY=0");
        end
    endtask

    task automatic wait_writes(input int k);
        int n;
        n = 0;
        while (nwr < k && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (nwr < k) begin
            checks++; errors++;
            $display("FAIL write wait timeout: got %0d writes expected %0d", nwr, k);
        end
    endtask

    task automatic finish_xfer(input string nm, input int n, input logic [3:0] ctrl);
        logic [31:0] st;
        logic f;
        f = ctrl[1] & FILL_EN;
        wait_done(st);
        chk({nm, " stat"}, st, f ? 32'hA : 32'h8);
        chk({nm, " cyc cycles"}, 32'(cyc_cnt), 32'(n * (f ? 2 : 4)));
        chk({nm, " writes"}, 32'(nwr), 32'(n));
        chk({nm, " pending"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] s, d;
        logic [3:0] c;
        int n, bad, cc;
        fork
            monitor();
        join_none
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat_w = '0; wb_sel = 4'hF;
        ld_en = 1'b0; ld_adr = '0; ld_dat = '0;
        for (int i = 0; i < 1024; i++) load(i, init_val(i));
        #1;
        chk("reset m_cyc", {31'b0, m_cyc}, 0);
        chk("reset m_stb", {31'b0, m_stb}, 0);
        chk("reset m_we", {31'b0, m_we}, 0);
        chk("reset m_sel", {28'b0, m_sel}, 0);
        chk("reset m_adr", m_adr, 0);
        chk("reset m_dat", m_dat_o, 0);
        chk("reset wb_ack", {31'b0, wb_ack}, 0);
        chk("reset wb_dat", wb_dat_r, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), r);
            chk("reset reg", r, 0);
        end
        // directed copy of 0xA0..0xA3
        for (int i = 0; i < 4; i++) load(16 + i, 32'hA0 + 32'(i));
        run(32'h10, 32'h80, 4, 4'h1);
        finish_xfer("copy4", 4, 4'h1);
        chk("copy4 cycles literal", 32'(cyc_cnt), 32'd16);
        for (int i = 0; i < 4; i++) chk("copy4 dst word", mem[128 + i], 32'hA0 + 32'(i));
        // zero length
        run(32'h10, 32'h90, 0, 4'h1);
        repeat (10) @(negedge clk);
        chk("len0 no cycles", 32'(cyc_cnt), 0);
        rd(2'd3, r);
        chk("len0 stat", r, 32'h8);
        // abort during the second word of an 8-word copy
        run(32'h100, 32'h300, 8, 4'h1);
        wait_writes(1);
        wr(2'd3, 32'h4);
        wait_done(r);
        chk("abort stat", r, 32'hC);
        chk("abort words 1 or 2", {31'b0, (nwr == 1 || nwr == 2)}, 1);
        cc = cyc_cnt;
        repeat (12) @(negedge clk);
        chk("abort no further cycles", 32'(cyc_cnt), 32'(cc));
        exp_q.delete();
        // register writes and START while busy are ignored
        run(32'h20, 32'h2A0, 6, 4'h1);
        wait_writes(1);
        wr(2'd2, 32'h55);
        wr(2'd0, 32'h3FF);
        wr(2'd3, 32'h1);
        rd(2'd2, r);
        chk("busy LEN readback", r, 6);
        rd(2'd0, r);
        chk("busy SRC readback", r, 32'h20);
        finish_xfer("busy", 6, 4'h1);
        // START together with DONE_CLR: START wins
        run(32'h30, 32'h2C0, 3, 4'h9);
        rd(2'd3, r);
        chk("start+clr stat", r, 32'h1);
        finish_xfer("start+clr", 3, 4'h9);
        wr(2'd3, 32'h8);
        rd(2'd3, r);
        chk("done_clr stat", r, 0);
        wr(2'd3, 32'h4);
        rd(2'd3, r);
        chk("idle abort stat", r, 0);
        xfer(1'b1, 2'd0, 32'h123, 4'h3, r);
        rd(2'd0, r);
        chk("partial sel ignored", r, 32'h30);
        // address wrap
        run(32'hFFFFFFFF, 32'h200, 2, 4'h1);
        finish_xfer("wrap", 2, 4'h1);
        chk("wrap first read", rd_log[0], 32'hFFFFFFFF);
        chk("wrap second read", rd_log[1], 32'h0);
        // fill (a copy when the feature is compiled out)
        run(32'hDEADBEEF, 32'h180, 3, 4'h3);
        finish_xfer("fill", 3, 4'h3);
        chk("fill reads", 32'(nrd), FILL_EN ? 32'd0 : 32'd3);
        chk("fill word0", mem[384], FILL_EN ? 32'hDEADBEEF : sh[384]);
        // randomized transfers
        for (int k = 0; k < 25; k++) begin
            s = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 6)) : $urandom;
            d = $urandom;
            n = $urandom_range(1, 8);
            c = {1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b1};
            run(s, d, n, c);
            finish_xfer("random", n, c);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== sh[i]) bad++;
        chk("memory image mismatches", 32'(bad), 0);
        // reset mid-transfer drops the master cycle asynchronously
        run(32'h40, 32'h240, 6, 4'h1);
        wait_writes(1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("async reset m_cyc", {31'b0, m_cyc}, 0);
        chk("async reset m_stb", {31'b0, m_stb}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        rd(2'd3, r);
        chk("post-reset stat", r, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wbdma.md
# wbdma

Single-channel Wishbone DMA engine that copies (or fills) blocks of 32-bit words in badge memory. It sits directly upstream of the `wbsram` / `wbspram` memory slaves: its master port drives their Wishbone inputs through the system interconnect. The CPU programs it through a small Wishbone slave register port, so bulk framebuffer and animation copies run without CPU load.

## Interface
- `AW`, 32: address width of both the master and the slave ports.
- `DW`, 32: data width; fixed at 32, with 4 byte lanes.
- `LEN_BITS`, 16: width of the transfer-length counter.

Ports:
- `wb_clk_i` in 1: clock for all logic.
- `wb_reset_i` in 1: reset, asynchronous, active-low.
- `wb_adr_i` in AW: slave register address; only bits [1:0] are decoded.
- `wb_dat_i` in DW: slave write data.
- `wb_dat_o` out DW: slave read data, registered.
- `wb_we_i`, `wb_sel_i`[DW/8], `wb_cyc_i`, `wb_stb_i` in: slave request signals.
- `wb_ack_o` out 1: slave acknowledge, registered.
- `m_adr_o` out AW: master word address.
- `m_dat_o` out DW: master write data.
- `m_dat_i` in DW: master read data.
- `m_we_o` out 1: master write enable.
- `m_sel_o` out DW/8: master byte select; always 4'hF during a transfer.
- `m_cyc_o`, `m_stb_o` out 1: master cycle and strobe.
- `m_ack_i` in 1: master acknowledge.

## Operation
- Slave registers (word index = `wb_adr_i[1:0]`):
  - 0 SRC: source word address.
  - 1 DST: destination word address.
  - 2 LEN: word count, `LEN_BITS` wide, zero-extended on read.
  - 3 CTRL/STAT.
- CTRL/STAT write bits:
  - bit0 START.
  - bit1 FILL (see Configuration).
  - bit2 ABORT.
  - bit3 DONE_CLR.
- CTRL/STAT read bits:
  - bit0 BUSY.
  - bit1 FILL latched.
  - bit2 ABORTED (sticky).
  - bit3 DONE (sticky).
- Slave access timing:
  - `wb_ack_o <= cyc & stb & ~wb_ack_o`, giving one-cycle latency.
  - Register writes are honoured only when `wb_sel_i` is 4'hF.
- Writes to SRC, DST or LEN while BUSY are acked and ignored.
- START while BUSY is ignored.
- START with LEN=0: no bus cycles; DONE=1 on the next cycle.
- On START: the working copies of src, dst and remaining load from SRC, DST and LEN. The programmed registers are not modified.
- Master FSM states:
  - IDLE: `m_cyc_o` = `m_stb_o` = 0.
  - READ: cyc=stb=1, we=0, adr=src. On `m_ack_i`, latch `m_dat_i` into the data register and go to WRITE.
  - WRITE: cyc=stb=1, we=1, adr=dst, `m_dat_o` = data register. On `m_ack_i`:
    - src += 1, dst += 1, remaining -= 1.
    - If remaining was 1, go to DONE; otherwise go to READ.
  - DONE: drop cyc/stb, set DONE, clear BUSY, return to IDLE.
- Address arithmetic wraps modulo 2^AW. No error is raised on wrap.
- ABORT while BUSY:
  - The outstanding bus cycle completes; the FSM waits for `m_ack_i`.
  - The FSM then goes to DONE with ABORTED=1.
  - A read-phase word that was fetched but not yet written is discarded.
- ABORT while IDLE has no effect.
- DONE_CLR clears DONE and ABORTED.
- START clears DONE and ABORTED. If DONE_CLR and START are in the same write, START wins: the transfer starts and both flags are 0.
- `m_stb_o` stays asserted for back-to-back requests. The address and `m_we_o` change in the cycle after ack, so the `wbsram` `~ack` gating prevents double access.

## Timing
- Reset values:
  - All outputs 0, FSM in IDLE.
  - SRC, DST, LEN and all status bits 0.
- START takes effect in the cycle after the slave ack. `m_cyc_o` rises one cycle after the CTRL write is sampled.
- Against `wbsram` (one-cycle ack), each copy word takes 4 cycles: READ request, READ ack, WRITE request, WRITE ack.
- An N-word copy holds `m_cyc_o` high for 4N cycles. DONE reads 1 on the cycle after the final write ack.
- Master outputs are registered and held stable until `m_ack_i` is sampled high.
- Reset asserted mid-transfer: `m_cyc_o`/`m_stb_o` drop asynchronously. No completion is reported.

## Configuration
- `WBDMA_FILL_EN`, when defined:
  - A START with FILL=1 skips the READ state.
  - Each word writes the value of the SRC register (pattern) to dst, then dst += 1.
  - Costs 2 cycles per word.
- `WBDMA_FILL_EN` undefined:
  - The FILL bit is ignored and reads 0.
  - All transfers are copies.

## Test plan
- Copy: SRC=0x10, DST=0x80, LEN=4, source data 0xA0..0xA3, START.
  - DST 0x80..0x83 = 0xA0..0xA3.
  - DONE=1 after 16 master cycles.
  - `m_sel_o` = 4'hF throughout.
- LEN=0 then START:
  - No `m_cyc_o` assertion.
  - STAT reads 0x8 (DONE=1, BUSY=0).
- ABORT during word 2 of an 8-word copy:
  - The current cycle completes and no further cycles follow.
  - STAT = 0xC (DONE=1, ABORTED=1).
  - Word count written is 1 or 2, never 3.
- Register writes while BUSY: write LEN=0x55 mid-transfer.
  - Readback still shows the original LEN.
  - The transfer completes the original count.
- Wrap: SRC = 2^AW−1, LEN=2. The master reads address 2^AW−1, then address 0.
- Fill (`WBDMA_FILL_EN` defined): SRC=0xDEADBEEF, FILL=1, LEN=3.
  - Three writes of 0xDEADBEEF and no reads.
  - DONE after 6 cycles.
  - With the macro undefined, the same programming performs a copy instead.
